// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Byte-addressed RV32I load/store front end for a word-organised data memory.
// Three-state machine (IDLE -> EXEC -> [WRITE] -> IDLE). Loads, SW and
// erroring requests complete in EXEC. SB/SH do a read-modify-write: the merged
// word is built in EXEC and written in WRITE.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/ready   CPU request handshake (ready only in IDLE)
//   is_store, funct3  request kind and RV32I width code
//   addr, store_data  byte address and store operand
//   resp_valid        one-cycle completion pulse
//   load_data, err    result and error flag, zero unless resp_valid
//   mem_address       word address (registered addr, upper bits dropped)
//   mem_write_data    word to write
//   mem_write_enable  memory writes on the next posedge
//   mem_read_data     combinational read of the word at mem_address
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [DATA_WIDTH-1:0]    store_data,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    load_data,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     is_store_q, is_store_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [ADDRESS_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]              store_data_q, store_data_d;
    logic [31:0]              merged_q, merged_d;

    logic                     req_err_s;
    logic                     req_ready_s;
    logic                     resp_valid_s;
    logic [31:0]              load_data_s;
    logic                     err_s;
    logic [31:0]              mem_write_data_s;
    logic                     mem_write_enable_s;

    // Misalignment or an funct3 code that is illegal for the request kind.
    function automatic logic req_error(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic e;
        e = 1'b0;
        case (f3)
            3'd0:    e = 1'b0;
            3'd1:    e = a[0];
            3'd2:    e = (a != 2'b00);
            3'd4:    e = st;
            3'd5:    e = st | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Pick the addressed byte/halfword and extend it according to funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'd0;
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Overlay the low byte/halfword of the store operand onto the memory word.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] a, input logic [31:0] d);
        logic [31:0] m;
        m = w;
        if (f3 == 3'd0) begin
            case (a)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                2'd3:    m[31:24] = d[7:0];
                default: m = w;
            endcase
        end else if (a[1]) begin
            m[31:16] = d[15:0];
        end else begin
            m[15:0] = d[15:0];
        end
        return m;
    endfunction

    assign req_err_s   = req_error(is_store_q, funct3_q, addr_q[1:0]);
    assign mem_address = addr_q[ADDRESS_WIDTH+1:2];

    // Next-state, request capture and unmasked output decode.
    always_comb begin
        state_d            = state_q;
        is_store_d         = is_store_q;
        funct3_d           = funct3_q;
        addr_d             = addr_q;
        store_data_d       = store_data_q;
        merged_d           = merged_q;
        req_ready_s        = 1'b0;
        resp_valid_s       = 1'b0;
        load_data_s        = 32'd0;
        err_s              = 1'b0;
        mem_write_data_s   = 32'd0;
        mem_write_enable_s = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    is_store_d   = is_store;
                    funct3_d     = funct3;
                    addr_d       = addr[ADDRESS_WIDTH+1:0];
                    store_data_d = store_data;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (req_err_s) begin
                    resp_valid_s = 1'b1;
                    err_s        = 1'b1;
                    state_d      = IDLE;
                end else if (!is_store_q) begin
                    resp_valid_s = 1'b1;
                    load_data_s  = load_extend(mem_read_data, funct3_q, addr_q[1:0]);
                    state_d      = IDLE;
                end else if (funct3_q == 3'd2) begin
                    resp_valid_s       = 1'b1;
                    mem_write_enable_s = 1'b1;
                    mem_write_data_s   = store_data_q;
                    state_d            = IDLE;
                end else begin
                    merged_d = store_merge(mem_read_data, funct3_q, addr_q[1:0], store_data_q);
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                resp_valid_s       = 1'b1;
                mem_write_enable_s = 1'b1;
                mem_write_data_s   = merged_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even mid-transaction.
    assign req_ready        = req_ready_s        & ~rst;
    assign resp_valid       = resp_valid_s       & ~rst;
    assign err              = err_s              & ~rst;
    assign mem_write_enable = mem_write_enable_s & ~rst;
    assign load_data        = rst ? 32'd0 : load_data_s;
    assign mem_write_data   = rst ? 32'd0 : mem_write_data_s;

    // State and captured request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            store_data_q <= 32'd0;
            merged_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            merged_q     <= merged_d;
        end
    end

    // Address bits above the memory window are deliberately ignored.
    if (ADDRESS_WIDTH < 30) begin : g_unused_addr
        logic unused_addr_hi_s;
        assign unused_addr_hi_s = ^addr[31:ADDRESS_WIDTH+2];
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data path width; only 32 is supported.
REQ-002 Parameter ADDRESS_WIDTH, default 30: word-address width driven to data memory.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 is_store  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-009 addr  input  32  byte address.
REQ-010 store_data  input  32  store operand; low bits used for B/H.
REQ-011 resp_valid  output  1  one-cycle pulse, request complete.
REQ-012 load_data  output  32  extended load result, valid with resp_valid.
REQ-013 err  output  1  misaligned or illegal funct3, valid with resp_valid.
REQ-014 mem_address  output  ADDRESS_WIDTH  word address to data memory (addr[31:2] truncated).
REQ-015 mem_write_data  output  32  word written to data memory.
REQ-016 mem_write_enable  output  1  memory writes mem_write_data on next posedge.
REQ-017 mem_read_data  input  32  combinational read of word at mem_address.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, WRITE; req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, req_valid=1 SHALL register is_store, funct3, addr, store_data and move to EXEC; otherwise stay IDLE.
REQ-020 mem_address SHALL be derived from the registered address, never from live addr.
REQ-021 Error at acceptance: H/HU with addr[0]=1, W with addr[1:0]!=0, load funct3 in {3,6,7}, store funct3 not in {0,1,2}.
REQ-022 EXEC, error: resp_valid=1, err=1, load_data=0, mem_write_enable=0, next IDLE.
REQ-023 EXEC, load: resp_valid=1; load_data = selected byte (addr[1:0]) or halfword (addr[1]) of mem_read_data, sign-extended for B/H, zero-extended for BU/HU, full word for W; next IDLE.
REQ-024 EXEC, SW: mem_write_enable=1, mem_write_data=store_data, resp_valid=1, next IDLE.
REQ-025 EXEC, SB/SH: read mem_read_data, register merged word (store_data[7:0] into byte addr[1:0], or store_data[15:0] into halfword addr[1]; other bytes unchanged), next WRITE; resp_valid=0, mem_write_enable=0.
REQ-026 WRITE: mem_write_enable=1, mem_write_data=merged word, resp_valid=1, next IDLE.
REQ-027 Latency from acceptance edge: loads, SW, errors complete 1 cycle later; SB/SH 2 cycles later.
REQ-028 A new request is accepted only in IDLE, so consecutive requests are separated by at least one IDLE cycle.
REQ-029 mem_write_enable SHALL be 0 in IDLE and whenever rst=1.
REQ-030 load_data and err SHALL be 0 whenever resp_valid=0.
REQ-031 Address bits above ADDRESS_WIDTH+1 SHALL be ignored (memory wraps).

Reset
REQ-032 rst=1 at posedge SHALL force IDLE and clear all registered request fields and merged word.
REQ-033 While rst=1: req_ready=0, resp_valid=0, mem_write_enable=0, load_data=0, err=0.
REQ-034 rst in EXEC or WRITE SHALL abort with no memory write and no response.
REQ-035 req_valid coincident with rst SHALL be dropped.

Verification
REQ-036 Mem[0x100>>2]=0x8899AABB; LB addr 0x101 -> resp 1 cycle after accept, load_data=0xFFFFFFAA, err=0.
REQ-037 Same word; LHU addr 0x102 -> load_data=0x00008899; LW addr 0x100 -> 0x8899AABB.
REQ-038 SB addr 0x103 data 0x12 -> write in WRITE cycle, resp 2 cycles after accept; then LW 0x100 -> 0x1299AABB.
REQ-039 SW addr 0x102 -> err=1, load_data=0, no mem_write_enable pulse, memory unchanged.
REQ-040 SH addr 0x200, rst asserted during WRITE -> no write, no resp_valid, req_ready=1 after rst drops.
REQ-041 Back-to-back req_valid held high: second request accepted only after return to IDLE; req_ready low in EXEC/WRITE.
